// File: rtl/alu_exec_stage.sv
// Registered MIPS ALU execute stage with a 2-entry (head + skid) output buffer,
// a printed-copy shadow for the trace monitor, and optional overflow flag (ALU_EXEC_OVF_EN).
module alu_exec_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic             in_Signed,
    input  logic [5:0]       in_ALUFunc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_A,
    output logic [31:0]      out_B,
    output logic [31:0]      out_S,
    output logic             out_Signed,
    output logic [5:0]       out_ALUFunc,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_badfunc,
    output logic             print_pulse,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_SUB = 6'b000001;
    localparam logic [5:0] F_AND = 6'b011000;
    localparam logic [5:0] F_OR  = 6'b011110;
    localparam logic [5:0] F_XOR = 6'b010110;
    localparam logic [5:0] F_NOR = 6'b010001;
    localparam logic [5:0] F_A   = 6'b011010;
    localparam logic [5:0] F_SLL = 6'b100000;
    localparam logic [5:0] F_SRL = 6'b100001;
    localparam logic [5:0] F_SRA = 6'b100011;
    localparam logic [5:0] F_EQ  = 6'b110011;
    localparam logic [5:0] F_NEQ = 6'b110001;
    localparam logic [5:0] F_LT  = 6'b110101;
    localparam logic [5:0] F_LEZ = 6'b111101;
    localparam logic [5:0] F_GEZ = 6'b111001;
    localparam logic [5:0] F_GTZ = 6'b111111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        sgn;
        logic [5:0]  func;
        logic        ovf;
        logic        bad;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state;
    entry_t           head;
    entry_t           skid;
    entry_t           shadow;
    entry_t           new_e;
    entry_t           view;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             accept;
    logic             emit;
    logic [4:0]       shamt;

    assign shamt  = in_A[4:0];
    assign accept = in_valid & in_ready_q;
    assign emit   = out_valid_q & out_ready;

    // Result is fixed at capture time; stored operands are never re-evaluated.
    always_comb begin
        new_e      = '0;
        new_e.a    = in_A;
        new_e.b    = in_B;
        new_e.sgn  = in_Signed;
        new_e.func = in_ALUFunc;
        case (in_ALUFunc)
            F_ADD: new_e.s = in_A + in_B;
            F_SUB: new_e.s = in_A - in_B;
            F_AND: new_e.s = in_A & in_B;
            F_OR:  new_e.s = in_A | in_B;
            F_XOR: new_e.s = in_A ^ in_B;
            F_NOR: new_e.s = ~(in_A | in_B);
            F_A:   new_e.s = in_A;
            F_SLL: new_e.s = in_B << shamt;
            F_SRL: new_e.s = in_B >> shamt;
            F_SRA: new_e.s = $signed(in_B) >>> shamt;
            F_EQ:  new_e.s = {31'd0, in_A == in_B};
            F_NEQ: new_e.s = {31'd0, in_A != in_B};
            F_LT:  new_e.s = {31'd0, in_Signed ? ($signed(in_A) < $signed(in_B)) : (in_A < in_B)};
            F_LEZ: new_e.s = {31'd0, $signed(in_A) <= 32'sd0};
            F_GEZ: new_e.s = {31'd0, $signed(in_A) >= 32'sd0};
            F_GTZ: new_e.s = {31'd0, $signed(in_A) > 32'sd0};
            default: begin
                new_e.s   = 32'd0;
                new_e.bad = 1'b1;
            end
        endcase
`ifdef ALU_EXEC_OVF_EN
        if (in_Signed && in_ALUFunc == F_ADD)
            new_e.ovf = (in_A[31] == in_B[31]) && (new_e.s[31] != in_A[31]);
        else if (in_Signed && in_ALUFunc == F_SUB)
            new_e.ovf = (in_A[31] != in_B[31]) && (new_e.s[31] != in_A[31]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            head        <= '0;
            skid        <= '0;
            shadow      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            print_pulse <= 1'b0;
            op_count    <= '0;
        end else begin
            print_pulse <= emit;
            if (emit) begin
                shadow   <= head;
                op_count <= op_count + CNT_W'(1);
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head        <= new_e;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        head <= new_e;
                    end else if (accept) begin
                        skid       <= new_e;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (emit) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        head       <= skid;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // When idle the buses show the last emitted (printed) entry instead of a stale head.
    assign view        = out_valid_q ? head : shadow;
    assign out_valid   = out_valid_q;
    assign in_ready    = in_ready_q;
    assign out_A       = view.a;
    assign out_B       = view.b;
    assign out_S       = view.s;
    assign out_Signed  = view.sgn;
    assign out_ALUFunc = view.func;
    assign out_zero    = (view.s == 32'd0);
    assign out_badfunc = view.bad;
`ifdef ALU_EXEC_OVF_EN
    assign out_ovf     = view.ovf;
`else
    assign out_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors, back-pressure, streaming,
// reset while full and counter wrap (CNT_W = 4).
module tb_alu_exec_stage;

    localparam int CNT_W = 4;

`ifdef ALU_EXEC_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_A;
    logic [31:0]      in_B;
    logic             in_Signed;
    logic [5:0]       in_ALUFunc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_A;
    logic [31:0]      out_B;
    logic [31:0]      out_S;
    logic             out_Signed;
    logic [5:0]       out_ALUFunc;
    logic             out_zero;
    logic             out_ovf;
    logic             out_badfunc;
    logic             print_pulse;
    logic [CNT_W-1:0] op_count;

    int               checks;
    int               passes;
    int               fails;
    logic [3:0]       exp_cnt;
    logic [31:0]      exp_q[$];
    logic [5:0]       codes[16] = '{6'h00, 6'h01, 6'h18, 6'h1E, 6'h16, 6'h11, 6'h1A, 6'h20,
                                    6'h21, 6'h23, 6'h33, 6'h31, 6'h35, 6'h3D, 6'h39, 6'h3F};

    alu_exec_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_Signed(in_Signed), .in_ALUFunc(in_ALUFunc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A(out_A), .out_B(out_B), .out_S(out_S),
        .out_Signed(out_Signed), .out_ALUFunc(out_ALUFunc),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_badfunc(out_badfunc),
        .print_pulse(print_pulse), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_s(input logic [31:0] a, input logic [31:0] b,
                                          input logic sg, input logic [5:0] fn);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (fn)
            6'h00: return a + b;
            6'h01: return a - b;
            6'h18: return a & b;
            6'h1E: return a | b;
            6'h16: return a ^ b;
            6'h11: return ~(a | b);
            6'h1A: return a;
            6'h20: return b << a[4:0];
            6'h21: return b >> a[4:0];
            6'h23: return sb >>> a[4:0];
            6'h33: return (a == b) ? 32'd1 : 32'd0;
            6'h31: return (a != b) ? 32'd1 : 32'd0;
            6'h35: return (sg ? (sa < sb) : (a < b)) ? 32'd1 : 32'd0;
            6'h3D: return (sa <= 0) ? 32'd1 : 32'd0;
            6'h39: return (sa >= 0) ? 32'd1 : 32'd0;
            6'h3F: return (sa > 0) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [5:0] fn);
        in_A       = a;
        in_B       = b;
        in_Signed  = sg;
        in_ALUFunc = fn;
    endtask

    // One op in, held one cycle with out_ready low, then popped.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [5:0] fn, input logic [31:0] exp_s,
                         input logic exp_bad, input logic exp_ovf);
        drive(a, b, sg, fn);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_s"}, out_S, exp_s);
        check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_s == 32'd0});
        check({tag, "_bad"}, {31'd0, out_badfunc}, {31'd0, exp_bad});
        check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
        check({tag, "_a"}, out_A, a);
        check({tag, "_func"}, {26'd0, out_ALUFunc}, {26'd0, fn});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt++;
        check({tag, "_pulse"}, {31'd0, print_pulse}, 32'd1);
        check({tag, "_cnt"}, {28'd0, op_count}, {28'd0, exp_cnt});
        check({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0; exp_cnt = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 6'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_pulse", {31'd0, print_pulse}, 32'd0);
        check("rst_cnt", {28'd0, op_count}, 32'd0);
        check("rst_s", out_S, 32'd0);
        check("rst_bad", {31'd0, out_badfunc}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_ovf",  32'h7FFFFFFF, 32'h1,        1'b1, 6'h00, 32'h80000000, 1'b0, OVF_EXP);
        do_op("add_uns",  32'h7FFFFFFF, 32'h1,        1'b0, 6'h00, 32'h80000000, 1'b0, 1'b0);
        do_op("sub_ovf",  32'h80000000, 32'h1,        1'b1, 6'h01, 32'h7FFFFFFF, 1'b0, OVF_EXP);
        do_op("sub",      32'd5,        32'd7,        1'b0, 6'h01, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("sra",      32'd4,        32'h80000000, 1'b0, 6'h23, 32'hF8000000, 1'b0, 1'b0);
        do_op("srl",      32'd4,        32'h80000000, 1'b0, 6'h21, 32'h08000000, 1'b0, 1'b0);
        do_op("sll",      32'd8,        32'h000000FF, 1'b0, 6'h20, 32'h0000FF00, 1'b0, 1'b0);
        do_op("nor",      32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 6'h11, 32'hF000F000, 1'b0, 1'b0);
        do_op("xor",      32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 6'h16, 32'hF0F00F0F, 1'b0, 1'b0);
        do_op("lt_s",     32'hFFFFFFFF, 32'h1,        1'b1, 6'h35, 32'd1,        1'b0, 1'b0);
        do_op("lt_u",     32'hFFFFFFFF, 32'h1,        1'b0, 6'h35, 32'd0,        1'b0, 1'b0);
        do_op("gtz0",     32'd0,        32'd0,        1'b0, 6'h3F, 32'd0,        1'b0, 1'b0);
        do_op("lez",      32'h80000000, 32'd0,        1'b0, 6'h3D, 32'd1,        1'b0, 1'b0);
        do_op("gez",      32'hFFFFFFFF, 32'd0,        1'b0, 6'h39, 32'd0,        1'b0, 1'b0);
        do_op("eq",       32'h1234,     32'h1234,     1'b0, 6'h33, 32'd1,        1'b0, 1'b0);
        do_op("neq",      32'd1,        32'd2,        1'b0, 6'h31, 32'd1,        1'b0, 1'b0);
        do_op("passa",    32'hDEADBEEF, 32'd3,        1'b0, 6'h1A, 32'hDEADBEEF, 1'b0, 1'b0);
        do_op("badfunc",  32'd9,        32'd9,        1'b0, 6'h3A, 32'd0,        1'b1, 1'b0);

        // Back-pressure: three ops with out_ready low, then drain.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(32'd1, 32'd1, 1'b0, 6'h00);
        @(posedge clk); #1;
        check("bp_ready1", {31'd0, in_ready}, 32'd1);
        drive(32'd2, 32'd2, 1'b0, 6'h00);
        @(posedge clk); #1;
        check("bp_ready2", {31'd0, in_ready}, 32'd0);
        drive(32'd3, 32'd3, 1'b0, 6'h00);
        @(posedge clk); #1;
        check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_s", out_S, 32'd2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        check("bp_op2", out_S, 32'd4);
        check("bp_pulse1", {31'd0, print_pulse}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_cnt++;
        check("bp_op3", out_S, 32'd6);
        check("bp_pulse2", {31'd0, print_pulse}, 32'd1);
        @(posedge clk); #1;
        exp_cnt++;
        check("bp_pulse3", {31'd0, print_pulse}, 32'd1);
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_cnt", {28'd0, op_count}, {28'd0, exp_cnt});
        @(posedge clk); #1;
        check("bp_pulse_off", {31'd0, print_pulse}, 32'd0);

        // Streaming: one op per cycle with both sides always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        sg;
            logic [5:0]  fn;
            a  = (i % 4 == 0) ? $urandom_range(0, 40) : $urandom;
            b  = $urandom;
            sg = 1'($urandom_range(0, 1));
            fn = codes[$urandom_range(0, 15)];
            drive(a, b, sg, fn);
            in_valid = 1'b1;
            exp_q.push_back(ref_s(a, b, sg, fn));
            @(posedge clk); #1;
            if (i > 0) exp_cnt++;
            check("st_ready", {31'd0, in_ready}, 32'd1);
            check("st_valid", {31'd0, out_valid}, 32'd1);
            check("st_s", out_S, exp_q.pop_front());
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        exp_cnt++;
        check("st_drained", {31'd0, out_valid}, 32'd0);
        check("st_cnt", {28'd0, op_count}, {28'd0, exp_cnt});

        // Reset while both entries are occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(32'd10, 32'd20, 1'b0, 6'h00);
        @(posedge clk); #1;
        drive(32'd30, 32'd40, 1'b0, 6'h00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_ready", {31'd0, in_ready}, 32'd0);
        check("full_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_cnt", {28'd0, op_count}, 32'd0);
        check("midrst_s", out_S, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_valid", {31'd0, out_valid}, 32'd0);

        // Counter wrap: 17 emits on a 4-bit counter.
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            in_valid = (i < 17);
            drive(i, 32'd1, 1'b0, 6'h00);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("wrap_cnt", {28'd0, op_count}, 32'd1);
        check("wrap_empty", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
